// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one word read per fetch request,
// and answers the controller's enable/finish handshake with the fetched word.
module ifu_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 255,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic              o_finish,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_next,
  output logic [ADDR_W-1:0] o_pc,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_fault,
  output logic              o_bus_req,
  output logic [ADDR_W-1:0] o_bus_addr,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  input  logic              i_bus_err,
  output logic [1:0]        o_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned      CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q,      state_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic [31:0]       inst_q,       inst_d;
  logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;
  logic              fault_q,      fault_d;
  logic              finish_q,     finish_d;
  logic              bus_req_q,    bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              redir_q,      redir_d;
  logic              enter_done_s;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Next-state logic for the fetch handshake, bus request and PC.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    fault_d      = 1'b0;
    finish_d     = 1'b0;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    fetch_addr_d = fetch_addr_q;
    cnt_d        = cnt_q;
    redir_d      = redir_q;
    enter_done_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_en) begin
          fetch_addr_d = pc_q;
          redir_d      = 1'b0;
          cnt_d        = '0;
          if (is_misaligned(pc_q)) begin
            state_d      = ST_DONE;
            enter_done_s = 1'b1;
            fault_d      = 1'b1;
            inst_d       = NOP_INST;
          end else begin
            state_d    = ST_REQ;
            bus_req_d  = 1'b1;
            bus_addr_d = pc_q;
          end
        end else begin
          bus_req_d = 1'b0;
        end
      end
      ST_REQ: begin
        if (i_bus_ack) begin
          state_d      = ST_DONE;
          bus_req_d    = 1'b0;
          enter_done_s = 1'b1;
          fault_d      = i_bus_err;
          inst_d       = i_bus_err ? NOP_INST : i_bus_rdata;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          state_d      = ST_DONE;
          bus_req_d    = 1'b0;
          enter_done_s = 1'b1;
          fault_d      = 1'b1;
          inst_d       = NOP_INST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase

    // A redirect seen during this fetch (or arriving now) owns the PC.
    if (enter_done_s) begin
      finish_d  = 1'b1;
      inst_pc_d = fetch_addr_d;
      if (!redir_d && !i_pc_load) begin
        pc_d = fetch_addr_d + ADDR_W'(4);
      end else begin
        pc_d = pc_q;
      end
    end else begin
      finish_d = 1'b0;
    end

    if (i_pc_load) begin
      pc_d    = i_pc_next;
      redir_d = 1'b1;
    end else begin
      redir_d = redir_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      fault_q      <= 1'b0;
      finish_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      fetch_addr_q <= RESET_PC;
      cnt_q        <= '0;
      redir_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      fault_q      <= fault_d;
      finish_q     <= finish_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      redir_q      <= redir_d;
    end
  end

  assign o_state    = state_q;
  assign o_pc       = pc_q;
  assign o_inst     = inst_q;
  assign o_inst_pc  = inst_pc_q;
  assign o_fault    = fault_q;
  assign o_finish   = finish_q;
  assign o_bus_req  = bus_req_q;
  assign o_bus_addr = bus_addr_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: expected fetch results are queued when a fetch
// is launched and popped when the unit reports completion.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en2;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        ack, err;
  logic [31:0] rdata;

  logic        finish, fault, bus_req;
  logic [31:0] pc, inst, inst_pc, bus_addr;
  logic [1:0]  state;

  logic        finish2, fault2, bus_req2;
  logic [31:0] pc2, inst2, inst_pc2, bus_addr2;
  logic [1:0]  state2;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [31:0] pc;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .o_finish(finish),
    .i_pc_load(pc_load), .i_pc_next(pc_next), .o_pc(pc),
    .o_inst(inst), .o_inst_pc(inst_pc), .o_fault(fault),
    .o_bus_req(bus_req), .o_bus_addr(bus_addr),
    .i_bus_ack(ack), .i_bus_rdata(rdata), .i_bus_err(err), .o_state(state)
  );

  ifu_fetch #(.TIMEOUT(4)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_en(en2), .o_finish(finish2),
    .i_pc_load(1'b0), .i_pc_next(32'h0000_0000), .o_pc(pc2),
    .o_inst(inst2), .o_inst_pc(inst_pc2), .o_fault(fault2),
    .o_bus_req(bus_req2), .o_bus_addr(bus_addr2),
    .i_bus_ack(1'b0), .i_bus_rdata(32'h0000_0000), .i_bus_err(1'b0), .o_state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_idle(input logic [31:0] v);
    pc_load = 1'b1;
    pc_next = v;
    @(negedge clk);
    pc_load = 1'b0;
    check("load_pc", pc, v);
    model_pc = v;
  endtask

  // One fetch: ack after 'delay' REQ cycles, optional redirect in REQ cycle load_at.
  task automatic do_fetch(input string tag, input logic [31:0] rd, input int delay,
                          input logic e, input int load_at, input logic [31:0] load_val);
    exp_t x;
    exp_t got;
    logic [31:0] addr;
    logic        mis;
    addr = model_pc;
    mis  = (addr[1:0] != 2'b00);
    x.fault   = mis | e;
    x.inst    = x.fault ? 32'h0000_0013 : rd;
    x.inst_pc = addr;
    x.pc      = (load_at >= 0) ? load_val : addr + 32'd4;
    sb_q.push_back(x);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    if (!mis) begin
      for (int c = 0; c <= delay; c++) begin
        check({tag, "_req"}, {31'd0, bus_req}, 32'd1);
        check({tag, "_addr"}, bus_addr, addr);
        check({tag, "_nofin"}, {31'd0, finish}, 32'd0);
        if (c == load_at) begin
          pc_load = 1'b1;
          pc_next = load_val;
        end
        if (c == delay) begin
          ack   = 1'b1;
          rdata = rd;
          err   = e;
        end
        @(negedge clk);
        ack     = 1'b0;
        err     = 1'b0;
        pc_load = 1'b0;
      end
    end else begin
      check({tag, "_noreq"}, {31'd0, bus_req}, 32'd0);
    end
    check({tag, "_finish"}, {31'd0, finish}, 32'd1);
    check({tag, "_state_done"}, {30'd0, state}, 32'd2);
    check({tag, "_req_drop"}, {31'd0, bus_req}, 32'd0);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check({tag, "_inst"}, inst, got.inst);
      check({tag, "_inst_pc"}, inst_pc, got.inst_pc);
      check({tag, "_fault"}, {31'd0, fault}, {31'd0, got.fault});
      check({tag, "_pc"}, pc, got.pc);
      model_pc = got.pc;
    end
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, finish}, 32'd0);
    check({tag, "_idle"}, {30'd0, state}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en2 = 1'b0; pc_load = 1'b0; pc_next = 32'd0;
    ack = 1'b0; err = 1'b0; rdata = 32'd0;
    model_pc = 32'd0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_finish", {31'd0, finish}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_req", {31'd0, bus_req}, 32'd0);
    check("rst_addr", bus_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_fetch("first", 32'h0050_0093, 0, 1'b0, -1, 32'd0);
    do_fetch("slow", 32'h00a0_0113, 5, 1'b0, -1, 32'd0);
    do_fetch("redir", 32'h0000_0073, 3, 1'b0, 1, 32'h0000_0100);
    do_fetch("target", 32'h1234_5678, 1, 1'b0, -1, 32'd0);

    // Ack with no request outstanding must be ignored.
    ack = 1'b1; rdata = 32'hdead_beef;
    @(negedge clk);
    ack = 1'b0;
    check("late_ack_fin", {31'd0, finish}, 32'd0);
    check("late_ack_inst", inst, 32'h1234_5678);

    load_idle(32'h0000_0102);
    do_fetch("misalign", 32'd0, 0, 1'b0, -1, 32'd0);
    load_idle(32'h0000_0200);
    do_fetch("buserr", 32'h0000_0fff, 2, 1'b1, -1, 32'd0);

    en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("to_req", {31'd0, bus_req2}, 32'd1);
      @(negedge clk);
    end
    check("to_finish", {31'd0, finish2}, 32'd1);
    check("to_fault", {31'd0, fault2}, 32'd1);
    check("to_inst", inst2, 32'h0000_0013);
    check("to_req_drop", {31'd0, bus_req2}, 32'd0);
    check("to_pc", pc2, 32'd4);

    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    check("abort_req", {31'd0, bus_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_req_drop", {31'd0, bus_req}, 32'd0);
    check("abort_pc", pc, 32'd0);
    check("abort_state", {30'd0, state}, 32'd0);
    check("abort_inst", inst, 32'h0000_0013);
    model_pc = 32'd0;
    @(negedge clk);

    load_idle(32'hffff_fffc);
    do_fetch("wrap", 32'h0000_0513, 0, 1'b0, -1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch unit; the responder side of the controller's fetch enable/finish handshake. It owns the PC. When enabled, it issues one word read on the instruction bus and latches the returned instruction. It then pulses finish so the controller can advance to decode.

Parameters:
ADDR_W, 32, PC and bus address width
RESET_PC, 32'h0000_0000, PC value after reset (ADDR_W bits)
TIMEOUT, 255, max cycles waiting for i_bus_ack before fault; 0 disables timeout
NOP_INST, 32'h0000_0013, instruction emitted on fault

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_en  in  1  fetch enable from controller (level, held until finish seen)
o_finish  out  1  one-cycle pulse: fetch complete, o_inst/o_fault valid
i_pc_load  in  1  load o_pc from i_pc_next (branch/jump redirect from EXU)
i_pc_next  in  ADDR_W  redirect target
o_pc  out  ADDR_W  current PC
o_inst  out  32  last fetched instruction (held until next completion)
o_inst_pc  out  ADDR_W  address o_inst was fetched from
o_fault  out  1  valid with o_finish: misaligned PC, bus error or timeout
o_bus_req  out  1  read request
o_bus_addr  out  ADDR_W  read address, stable while o_bus_req=1
i_bus_ack  in  1  read complete; may arrive in the first cycle of o_bus_req
i_bus_rdata  in  32  read data, valid when i_bus_ack=1
i_bus_err  in  1  bus error, qualified by i_bus_ack
o_state  out  2  debug: 0 IDLE, 1 REQ, 2 DONE

Behaviour:
- All outputs registered. Reset: state IDLE, o_pc=RESET_PC, o_inst=NOP_INST, o_inst_pc=RESET_PC, o_finish=0, o_fault=0, o_bus_req=0, o_bus_addr=0, timeout counter 0, redirect flag 0.
- IDLE: if i_en=1, latch fetch_addr=o_pc.
  - If o_pc[1:0]!=0: go to DONE with fault; no bus request.
  - Otherwise go to REQ with o_bus_req=1 and o_bus_addr=o_pc, both visible the next cycle.
- REQ: hold o_bus_req and o_bus_addr.
  - On i_bus_ack: drop req the next cycle, go to DONE, and capture o_inst=i_bus_rdata. If i_bus_err=1, capture o_inst=NOP_INST and set fault.
  - If TIMEOUT!=0 and the wait counter reaches TIMEOUT with no ack: drop req, o_inst=NOP_INST, fault, go to DONE. Late acks are ignored in all other states.
- DONE: o_finish=1 and o_fault valid for exactly one cycle. o_inst_pc=fetch_addr. Next state IDLE.
- i_en is ignored outside IDLE. The controller drops i_en at the edge where it samples o_finish, so IDLE sees i_en=0. If i_en is still 1 in IDLE, a new fetch starts; this is legal.
- Latency: i_en high in IDLE cycle k -> o_bus_req in cycle k+1. Ack in cycle k+1 -> o_finish in cycle k+2, which is the minimum. Misaligned PC -> o_finish in cycle k+1.
- PC update:
  - i_pc_load=1 in any state: o_pc <= i_pc_next next cycle and sets the redirect flag.
  - Entering DONE with the redirect flag clear (and no i_pc_load that cycle): o_pc <= fetch_addr+4, wrapping modulo 2^ADDR_W. This also applies on fault.
  - Entering DONE with the redirect flag set or i_pc_load=1: keep the loaded value.
  - The redirect flag clears when a new fetch starts.
- A load during REQ never changes the outstanding o_bus_addr.
- i_rst mid-fetch: everything returns to reset values next cycle, and o_bus_req deasserts even without ack. The bus must tolerate an abandoned request.

Test Plan:
- Reset, i_en=1, ack in first req cycle with rdata=32'h00500093 -> o_bus_addr=0, o_finish 2 cycles after i_en, o_inst=32'h00500093, o_inst_pc=0, o_pc=4, o_fault=0.
- Ack delayed 5 cycles -> o_bus_req and o_bus_addr stable for 6 cycles, single o_finish pulse, o_pc advances by 4.
- i_pc_load=1 with i_pc_next=32'h100 during REQ at pc=8 -> bus still reads 8, o_inst_pc=8, final o_pc=32'h100. Then the next fetch reads 32'h100.
- i_pc_next=32'h102 loaded, then i_en -> no o_bus_req, o_finish+o_fault next cycle, o_inst=32'h13, o_pc=32'h106.
- Ack with i_bus_err=1 -> o_fault=1, o_inst=32'h13. With TIMEOUT=4 and no ack -> req dropped after 4 cycles, o_fault=1.
- i_rst asserted during REQ -> o_bus_req=0 next cycle, o_pc=RESET_PC, o_state=0. PC=32'hFFFF_FFFC fetch -> o_pc wraps to 0.
